// File: rtl/mutative_types.sv
// Shared constants and types for the mutative cache line adapter.
// Line geometry is fixed here; BEATS is derived and must not be overridden.
package mutative_types;

  localparam int LINE_BITS     = 256;
  localparam int BEAT_BITS     = 64;
  localparam int BEATS         = LINE_BITS / BEAT_BITS;
  localparam int BEAT_IDX_BITS = $clog2(BEATS);
  localparam int OFFSET_BITS   = $clog2(LINE_BITS / 8);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_BEAT,
    WR_BEAT,
    RESP
  } line_adapter_state_t;

  typedef logic [BEAT_IDX_BITS-1:0] beat_idx_t;

  // Strip the byte offset so the burst always targets the start of the line.
  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/mutative_line_adapter_if.sv
// Cache-side (dfp) and memory-side (bmem) signals of the line adapter.
// slave: the adapter's view. master: the cache + burst memory view.
interface mutative_line_adapter_if;
  import mutative_types::*;

  logic [31:0]          dfp_addr;
  logic                 dfp_read;
  logic                 dfp_write;
  logic [LINE_BITS-1:0] dfp_wdata;
  logic [LINE_BITS-1:0] dfp_rdata;
  logic                 dfp_resp;

  logic [31:0]          bmem_addr;
  logic                 bmem_read;
  logic                 bmem_write;
  logic [BEAT_BITS-1:0] bmem_wdata;
  logic                 bmem_ready;
  logic [31:0]          bmem_raddr;
  logic [BEAT_BITS-1:0] bmem_rdata;
  logic                 bmem_rvalid;

  logic                 proto_err;

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output proto_err
  );

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  proto_err
  );

endinterface

// File: rtl/mutative_beat_buffer.sv
// One cacheline register: full-line load (writeback capture), indexed beat
// write (read assembly) and indexed beat read (writeback serialisation).
module mutative_beat_buffer
  import mutative_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic [LINE_BITS-1:0] load_line,
  input  logic                 beat_we,
  input  beat_idx_t            beat_widx,
  input  logic [BEAT_BITS-1:0] beat_wdata,
  input  beat_idx_t            beat_ridx,
  output logic [BEAT_BITS-1:0] beat_rdata,
  output logic [LINE_BITS-1:0] line
);

  logic [LINE_BITS-1:0] line_q;

  // Capture a whole writeback line, or drop one returned beat into its slot.
  always_ff @(posedge clk) begin
    // NOTE: this wide register is cleared on reset on purpose, so a burst cut
    // short by reset never leaves stale data visible; most buffers skip this.
    if (rst) begin
      line_q <= '0;
    end else if (load_en) begin
      // NOTE: state is always updated with <= so every flop samples the
      // pre-edge values regardless of statement order.
      line_q <= load_line;
    end else if (beat_we) begin
      line_q[BEAT_BITS*beat_widx +: BEAT_BITS] <= beat_wdata;
    end
  end

  assign beat_rdata = line_q[BEAT_BITS*beat_ridx +: BEAT_BITS];
  assign line       = line_q;

endmodule

// File: rtl/mutative_line_adapter.sv
// Line adapter under the mutative cache: turns one 256-bit line read/write
// into a 4-beat 64-bit burst and answers the cache with a one-cycle dfp_resp.
// Optional: define MUTATIVE_LINE_ADAPTER_RADDR_CHECK_EN to drop read beats
// whose bmem_raddr does not match the line being filled and raise proto_err.
module mutative_line_adapter
  import mutative_types::*;
(
  input logic                     clk,
  input logic                     rst,
  mutative_line_adapter_if.slave  bus
);

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

  line_adapter_state_t  state_q, state_d;
  logic [31:0]          addr_q;
  logic                 is_write_q;
  beat_idx_t            cnt_q;
  logic [LINE_BITS-1:0] rdata_q;

  logic                 start_wr;
  logic                 start_rd;
  logic                 beat_we;
  logic                 cnt_inc;
  logic                 bmem_read_c;
  logic                 bmem_write_c;
  logic                 resp_c;
  logic                 beat_addr_ok;

  logic [LINE_BITS-1:0] buf_line;
  logic [BEAT_BITS-1:0] buf_beat;

`ifdef MUTATIVE_LINE_ADAPTER_RADDR_CHECK_EN
  logic err_q;

  assign beat_addr_ok = (bus.bmem_raddr == addr_q);

  // Sticky flag: a mistagged beat in RD_BEAT, or any beat outside RD_BEAT.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus.bmem_rvalid && ((state_q != RD_BEAT) || !beat_addr_ok)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.proto_err = err_q;
`else
  logic unused_raddr;

  assign unused_raddr  = ^bus.bmem_raddr;
  assign beat_addr_ok  = 1'b1;
  assign bus.proto_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state controls; write wins when both requests are up.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    start_wr     = 1'b0;
    start_rd     = 1'b0;
    beat_we      = 1'b0;
    cnt_inc      = 1'b0;
    bmem_read_c  = 1'b0;
    bmem_write_c = 1'b0;
    resp_c       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.dfp_write) begin
          start_wr = 1'b1;
          state_d  = WR_BEAT;
        end else if (bus.dfp_read) begin
          start_rd = 1'b1;
          state_d  = RD_REQ;
        end
      end
      RD_REQ: begin
        bmem_read_c = 1'b1;
        if (bus.bmem_ready) state_d = RD_BEAT;
      end
      RD_BEAT: begin
        if (bus.bmem_rvalid && beat_addr_ok) begin
          beat_we = 1'b1;
          cnt_inc = 1'b1;
          if (cnt_q == LAST_BEAT) state_d = RESP;
        end
      end
      WR_BEAT: begin
        bmem_write_c = 1'b1;
        if (bus.bmem_ready) begin
          cnt_inc = 1'b1;
          if (cnt_q == LAST_BEAT) state_d = RESP;
        end
      end
      RESP: begin
        resp_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, beat counter (wraps to 0 on the last beat) and the
  // persistent copy of the most recent read line.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      is_write_q <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
    end else begin
      if (start_wr || start_rd) begin
        addr_q     <= line_addr(bus.dfp_addr);
        is_write_q <= start_wr;
        cnt_q      <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if ((state_q == RESP) && !is_write_q) begin
        rdata_q <= buf_line;
      end
    end
  end

  mutative_beat_buffer u_buffer (
    .clk        (clk),
    .rst        (rst),
    .load_en    (start_wr),
    .load_line  (bus.dfp_wdata),
    .beat_we    (beat_we),
    .beat_widx  (cnt_q),
    .beat_wdata (bus.bmem_rdata),
    .beat_ridx  (cnt_q),
    .beat_rdata (buf_beat),
    .line       (buf_line)
  );

  assign bus.bmem_read  = bmem_read_c;
  assign bus.bmem_write = bmem_write_c;
  assign bus.bmem_addr  = (bmem_read_c || bmem_write_c) ? addr_q : 32'h0;
  assign bus.bmem_wdata = bmem_write_c ? buf_beat : '0;
  assign bus.dfp_resp   = resp_c;
  // The response cycle shows the fresh read line, or zero for a writeback;
  // otherwise the last completed read line is held.
  assign bus.dfp_rdata  = (state_q == RESP) ? (is_write_q ? '0 : buf_line) : rdata_q;

endmodule

// File: tb/tb_mutative_line_adapter.sv
// Directed bench for mutative_line_adapter: reads with and without gaps,
// stalled writeback, write/read collision, mid-burst reset and, when
// MUTATIVE_LINE_ADAPTER_RADDR_CHECK_EN is defined, the beat address check.
module tb_mutative_line_adapter;
  import mutative_types::*;

  logic clk = 1'b0;
  logic rst;

  mutative_line_adapter_if bus ();

  mutative_line_adapter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int resp_cnt = 0;
  int rd_acc   = 0;

  logic [63:0] beats [4];

  // Count completion pulses and accepted read bursts at each active edge.
  always @(posedge clk) begin
    if (bus.dfp_resp) resp_cnt++;
    if (bus.bmem_read && bus.bmem_ready) rd_acc++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic give_beat(input logic [63:0] data, input logic [31:0] raddr);
    bus.bmem_rvalid = 1'b1;
    bus.bmem_rdata  = data;
    bus.bmem_raddr  = raddr;
    tick();
    bus.bmem_rvalid = 1'b0;
  endtask

  // Feed the four beats of the global beats[] array, with idle gaps between.
  task automatic read_beats(input int gap, input logic [31:0] raddr);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.bmem_rvalid = 1'b0;
        settle();
        check("no_resp_in_gap", bus.dfp_resp, 0);
        tick();
      end
      bus.bmem_rvalid = 1'b1;
      bus.bmem_rdata  = beats[i];
      bus.bmem_raddr  = raddr;
      settle();
      check("no_early_resp", bus.dfp_resp, 0);
      tick();
    end
    bus.bmem_rvalid = 1'b0;
  endtask

  logic [255:0] line_a;
  logic [255:0] line_e;
  int           r0;
  int           c0;

  initial begin
    rst             = 1'b1;
    bus.dfp_addr    = '0;
    bus.dfp_read    = 1'b0;
    bus.dfp_write   = 1'b0;
    bus.dfp_wdata   = '0;
    bus.bmem_ready  = 1'b0;
    bus.bmem_raddr  = '0;
    bus.bmem_rdata  = '0;
    bus.bmem_rvalid = 1'b0;
    tick();
    tick();

    // ---- reset state
    check("rst_resp",      bus.dfp_resp,   0);
    check("rst_bmem_read", bus.bmem_read,  0);
    check("rst_bmem_wr",   bus.bmem_write, 0);
    check("rst_bmem_addr", bus.bmem_addr,  0);
    check("rst_rdata",     bus.dfp_rdata,  0);
    check("rst_proto_err", bus.proto_err,  0);
    rst = 1'b0;
    tick();

    // ---- read, no gaps
    beats[0] = 64'h1111_1111_1111_1111;
    beats[1] = 64'h2222_2222_2222_2222;
    beats[2] = 64'h3333_3333_3333_3333;
    beats[3] = 64'h4444_4444_4444_4444;
    line_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    bus.dfp_addr   = 32'h0000_1234;
    bus.dfp_read   = 1'b1;
    bus.bmem_ready = 1'b1;
    settle();
    check("rd1_idle_no_req", bus.bmem_read, 0);
    tick();
    check("rd1_bmem_read", bus.bmem_read, 1);
    check("rd1_bmem_addr", bus.bmem_addr, 32'h0000_1220);
    tick();
    check("rd1_req_dropped", bus.bmem_read, 0);
    read_beats(0, 32'h0000_1220);
    bus.dfp_read = 1'b0;
    settle();
    check("rd1_resp",  bus.dfp_resp,  1);
    check("rd1_line",  bus.dfp_rdata, line_a);
    tick();
    check("rd1_resp_one_cycle", bus.dfp_resp,  0);
    check("rd1_line_held",      bus.dfp_rdata, line_a);
    check("rd1_one_bmem_read",  rd_acc,   1);
    check("rd1_one_resp",       resp_cnt, 1);

    // ---- read with 2-cycle gaps
    r0 = rd_acc;
    c0 = resp_cnt;
    bus.dfp_addr = 32'h0000_1234;
    bus.dfp_read = 1'b1;
    tick();
    check("rd2_bmem_addr", bus.bmem_addr, 32'h0000_1220);
    tick();
    read_beats(2, 32'h0000_1220);
    bus.dfp_read = 1'b0;
    settle();
    check("rd2_resp", bus.dfp_resp,  1);
    check("rd2_line", bus.dfp_rdata, line_a);
    tick();
    check("rd2_one_bmem_read", rd_acc - r0,   1);
    check("rd2_one_resp",      resp_cnt - c0, 1);

    // ---- write with 3-cycle stall on beat 1
    c0 = resp_cnt;
    bus.dfp_addr  = 32'h8000_0040;
    bus.dfp_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    bus.dfp_write  = 1'b1;
    bus.bmem_ready = 1'b1;
    tick();
    check("wr_valid_a", bus.bmem_write, 1);
    check("wr_addr",    bus.bmem_addr,  32'h8000_0040);
    check("wr_beat_a",  bus.bmem_wdata, 64'hAAAA_AAAA_AAAA_AAAA);
    tick();
    bus.bmem_ready = 1'b0;
    settle();
    for (int s = 0; s < 3; s++) begin
      check("wr_stall_valid", bus.bmem_write, 1);
      check("wr_stall_b",     bus.bmem_wdata, 64'hBBBB_BBBB_BBBB_BBBB);
      tick();
    end
    bus.bmem_ready = 1'b1;
    settle();
    check("wr_beat_b", bus.bmem_wdata, 64'hBBBB_BBBB_BBBB_BBBB);
    tick();
    check("wr_beat_c", bus.bmem_wdata, 64'hCCCC_CCCC_CCCC_CCCC);
    tick();
    check("wr_beat_d",     bus.bmem_wdata, 64'hDDDD_DDDD_DDDD_DDDD);
    check("wr_no_early",   bus.dfp_resp,   0);
    tick();
    bus.dfp_write = 1'b0;
    settle();
    check("wr_resp",        bus.dfp_resp,   1);
    check("wr_rdata_zero",  bus.dfp_rdata,  0);
    check("wr_write_low",   bus.bmem_write, 0);
    tick();
    check("wr_one_resp",    resp_cnt - c0,  1);
    check("wr_rdata_held",  bus.dfp_rdata,  line_a);

    // ---- simultaneous read+write, then back-to-back read
    r0 = rd_acc;
    bus.dfp_addr  = 32'h0000_2000;
    bus.dfp_wdata = {4{64'h0123_4567_89AB_CDEF}};
    bus.dfp_read  = 1'b1;
    bus.dfp_write = 1'b1;
    tick();
    check("sim_write_first", bus.bmem_write, 1);
    check("sim_no_read",     bus.bmem_read,  0);
    tick();
    tick();
    tick();
    tick();
    bus.dfp_write = 1'b0;
    settle();
    check("sim_wr_resp",      bus.dfp_resp,  1);
    check("sim_resp_no_read", bus.bmem_read, 0);
    tick();
    check("sim_idle_no_read", bus.bmem_read, 0);
    tick();
    check("sim_rd_req",  bus.bmem_read, 1);
    check("sim_rd_addr", bus.bmem_addr, 32'h0000_2000);
    tick();
    read_beats(0, 32'h0000_2000);
    bus.dfp_read = 1'b0;
    settle();
    check("sim_rd_resp", bus.dfp_resp,  1);
    check("sim_rd_line", bus.dfp_rdata, line_a);
    tick();
    check("sim_one_bmem_read", rd_acc - r0, 1);

    // ---- reset in the middle of a read burst
    bus.dfp_addr = 32'h0000_0040;
    bus.dfp_read = 1'b1;
    tick();
    tick();
    give_beat(beats[0], 32'h0000_0040);
    give_beat(beats[1], 32'h0000_0040);
    bus.dfp_read = 1'b0;
    c0  = resp_cnt;
    rst = 1'b1;
    tick();
    check("mrst_read",  bus.bmem_read,  0);
    check("mrst_write", bus.bmem_write, 0);
    check("mrst_addr",  bus.bmem_addr,  0);
    check("mrst_resp",  bus.dfp_resp,   0);
    check("mrst_rdata", bus.dfp_rdata,  0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("mrst_no_resp", resp_cnt - c0, 0);
    beats[0] = 64'hE1E1_E1E1_E1E1_E1E1;
    beats[1] = 64'hE2E2_E2E2_E2E2_E2E2;
    beats[2] = 64'hE3E3_E3E3_E3E3_E3E3;
    beats[3] = 64'hE4E4_E4E4_E4E4_E4E4;
    line_e = {64'hE4E4_E4E4_E4E4_E4E4, 64'hE3E3_E3E3_E3E3_E3E3,
              64'hE2E2_E2E2_E2E2_E2E2, 64'hE1E1_E1E1_E1E1_E1E1};
    bus.dfp_addr = 32'h0000_0060;
    bus.dfp_read = 1'b1;
    tick();
    check("mrst_new_addr", bus.bmem_addr, 32'h0000_0060);
    tick();
    read_beats(0, 32'h0000_0060);
    bus.dfp_read = 1'b0;
    settle();
    check("mrst_new_resp", bus.dfp_resp,  1);
    check("mrst_new_line", bus.dfp_rdata, line_e);
    tick();

`ifdef MUTATIVE_LINE_ADAPTER_RADDR_CHECK_EN
    // ---- mistagged beat is dropped and flagged
    beats[0] = 64'h1111_1111_1111_1111;
    beats[1] = 64'h2222_2222_2222_2222;
    beats[2] = 64'h3333_3333_3333_3333;
    beats[3] = 64'h4444_4444_4444_4444;
    bus.dfp_addr = 32'h0000_1234;
    bus.dfp_read = 1'b1;
    tick();
    tick();
    give_beat(beats[0], 32'h0000_1220);
    give_beat(beats[1], 32'h0000_1220);
    check("chk_err_clear", bus.proto_err, 0);
    give_beat(64'hBAD0_BAD0_BAD0_BAD0, 32'hDEAD_0000);
    check("chk_err_set",    bus.proto_err, 1);
    check("chk_no_resp",    bus.dfp_resp,  0);
    give_beat(beats[2], 32'h0000_1220);
    check("chk_no_resp_3",  bus.dfp_resp,  0);
    give_beat(beats[3], 32'h0000_1220);
    bus.dfp_read = 1'b0;
    settle();
    check("chk_resp",       bus.dfp_resp,  1);
    check("chk_line",       bus.dfp_rdata, line_a);
    tick();
    tick();
    check("chk_err_sticky", bus.proto_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("chk_err_rst",    bus.proto_err, 0);
`else
    // ---- without the check, a stray beat is ignored and never flagged
    c0 = resp_cnt;
    give_beat(64'hBAD0_BAD0_BAD0_BAD0, 32'hDEAD_0000);
    check("nochk_err",     bus.proto_err, 0);
    check("nochk_no_req",  bus.bmem_read, 0);
    tick();
    check("nochk_no_resp", resp_cnt - c0, 0);
    check("nochk_rdata",   bus.dfp_rdata, line_e);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mutative_line_adapter.md
Name: mutative_line_adapter

Overview:
- Sits directly below the mutative cache on its downward-facing port (dfp).
- Converts each 256-bit cacheline read or write into a 4-beat, 64-bit burst transaction on the burst memory port (bmem).
- Collects read beats into one line and returns it with a single-cycle dfp_resp.
- Serialises writeback lines into beats and acknowledges with dfp_resp after the last beat is accepted.

Parameters:
- LINE_BITS, 256: cacheline width; must equal the cache dfp data width.
- BEAT_BITS, 64: burst beat width. LINE_BITS must be an integer multiple.
- BEATS, LINE_BITS/BEAT_BITS (4): beats per line; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dfp_addr  in  32  line address from cache (low 5 bits ignored)
- dfp_read  in  1  line read request, held by cache until dfp_resp
- dfp_write  in  1  line write request, held by cache until dfp_resp
- dfp_wdata  in  LINE_BITS  line to write
- dfp_rdata  out  LINE_BITS  assembled read line
- dfp_resp  out  1  one-cycle completion pulse
- bmem_addr  out  32  burst line address, low 5 bits zero
- bmem_read  out  1  read burst request
- bmem_write  out  1  write beat valid
- bmem_wdata  out  BEAT_BITS  write beat data
- bmem_ready  in  1  memory accepts request/beat this cycle
- bmem_raddr  in  32  line address tagging the returned beat
- bmem_rdata  in  BEAT_BITS  read beat data
- bmem_rvalid  in  1  read beat valid
- proto_err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (rst, synchronous, active-high; clock clk): all outputs 0, state IDLE, beat counter 0, line buffer 0. A reset mid-burst abandons the burst; no dfp_resp is generated.
- States: IDLE, RD_REQ, RD_BEAT, WR_BEAT, RESP.
- IDLE, request arbitration:
  - dfp_write has priority over dfp_read; both high together is served as a write.
  - On dfp_write: latch dfp_wdata and line address {dfp_addr[31:5],5'b0}, clear counter, go to WR_BEAT.
  - Else on dfp_read: latch the line address, go to RD_REQ.
- RD_REQ:
  - bmem_read=1 and bmem_addr=latched address.
  - Stay until bmem_ready=1, then go to RD_BEAT. Exactly one accepted bmem_read per line.
- RD_BEAT:
  - Each cycle with bmem_rvalid=1 writes bmem_rdata into buffer bits [BEAT_BITS*k +: BEAT_BITS], k = counter, then increments k.
  - Gaps between beats are allowed.
  - On the beat where k=BEATS-1: go to RESP and hold the buffer.
- WR_BEAT:
  - bmem_write=1, bmem_addr=latched address, bmem_wdata=buffer slice k.
  - k advances only when bmem_ready=1; a stalled beat is held unchanged.
  - After beat BEATS-1 is accepted, go to RESP.
- RESP:
  - dfp_resp=1 for exactly one cycle. dfp_rdata equals the assembled line for reads and 0 for writes.
  - Next state is IDLE unconditionally.
  - A request still high in the RESP cycle is not sampled; a new request is taken from the IDLE cycle after.
- Latency:
  - Read: dfp_resp is the cycle after the 4th rvalid.
  - Write, no stall: bmem_write high 4 cycles, dfp_resp on the 5th cycle after leaving IDLE.
- bmem_rvalid outside RD_BEAT is ignored.
- Counter width is clog2(BEATS). It wraps to 0 on burst completion, never mid-burst.
- dfp_rdata keeps its value until the next read completes. Only the RESP cycle is architecturally meaningful.

Optional Feature:
- Macro: MUTATIVE_LINE_ADAPTER_RADDR_CHECK_EN.
- Defined:
  - In RD_BEAT, a beat whose bmem_raddr differs from the latched line address is not stored and does not advance k.
  - proto_err is set and stays set until rst.
  - rvalid in any other state also sets proto_err.
- Undefined: bmem_raddr is unused, all rvalid beats in RD_BEAT are accepted, and proto_err is tied 0.

Decomposition:
- mutative_types package gains:
  - constants LINE_BITS, BEAT_BITS, BEATS, BEAT_IDX_BITS
  - enum line_adapter_state_t {IDLE, RD_REQ, RD_BEAT, WR_BEAT, RESP}
- One sub-module: mutative_beat_buffer, a LINE_BITS register with an indexed beat write port (reads) and an indexed beat read port (writes).

Test Plan:
- Read, no gaps: dfp_read addr 0x0000_1234; bmem_ready=1; beats 0x11..,0x22..,0x33..,0x44.. → bmem_read once with addr 0x0000_1220; dfp_resp one cycle after beat 4 with line {0x44..,0x33..,0x22..,0x11..}.
- Read with gaps: same read, 2 idle cycles between each beat → identical line; dfp_resp exactly one cycle after the last beat.
- Write with stalls: dfp_write addr 0x8000_0040, wdata beats A,B,C,D; bmem_ready low for beat 1 during 3 cycles → beat order A,B,C,D; B held for 3 cycles; single dfp_resp after D accepted.
- Simultaneous request and back-to-back: dfp_read=dfp_write=1 → write served first. The cache then holds read → read burst starts from the IDLE cycle after RESP, with no duplicate bmem_read.
- Reset mid-burst: rst after 2 read beats → all outputs 0; no dfp_resp. A new read completes correctly with counter restarted at 0.
- Address check (macro defined): the 3rd beat carries bmem_raddr 0xDEAD_0000 → beat dropped and proto_err=1. The 4 correct beats complete the line; proto_err stays 1 until rst.
